// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the instruction prefetch queue: controller state
// encoding, default parameter values and a counter-width helper.
// -----------------------------------------------------------------------------
package core_pkg;

  // Controller states of the prefetch queue
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } pq_state_e;

  localparam int          DEF_ADDR_W   = 16;
  localparam int          DEF_INST_W   = 16;
  localparam int          DEF_DEPTH    = 4;
  localparam int unsigned DEF_RESET_PC = 32'd0;

  // Occupancy / in-flight counters must be able to hold the value DEPTH itself
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Parametrised FIFO storage for the prefetch queue. Head entry is presented
// directly from storage (first-word fall-through on the registered array).
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   i_flush        empty the FIFO (priority over push/pop)
//   i_push         write i_push_data at the tail
//   i_push_data    entry to store
//   i_pop          drop the head entry
//   o_head_data    current head entry
//   o_count        number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module fetch_fifo
  import core_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_data,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign w_do_pop  = i_pop && (r_count != {CNT_W{1'b0}});
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_count     = r_count;

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (i_flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1'b1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/prefetch_queue.sv
// -----------------------------------------------------------------------------
// prefetch_queue
// Sequential word-addressed instruction prefetcher with redirect support.
// Issues fetch requests while (stored + in-flight) < DEPTH, buffers responses
// with their next-PC in fetch_fifo and hands them to decode in order.
//
// Build option: define PREFETCH_BYPASS_EN to let a response that arrives while
// the queue is empty appear on inst_if/npc_if in the same cycle. Without it a
// response becomes visible the cycle after it arrives.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   target/target_en redirect address and strobe (flushes queue)
//   mem_req/mem_gnt  fetch request handshake, to_mem_addr = word address
//   mem_rvalid       in-order response strobe, from_mem_data = response word
//   inst_valid/inst_ready  decode handshake
//   inst_if, npc_if  head instruction word and its address plus one
// -----------------------------------------------------------------------------
module prefetch_queue
  import core_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] target,
  input  logic              target_en,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] to_mem_addr,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] from_mem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_if,
  output logic [ADDR_W-1:0] npc_if
);

  localparam int               CNT_W    = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(DEPTH);

  pq_state_e                r_state;
  pq_state_e                w_state_next;
  logic [ADDR_W-1:0]        r_pc;
  logic [ADDR_W-1:0]        w_pc_next;
  logic [CNT_W-1:0]         r_in_flight;
  logic [CNT_W-1:0]         w_in_flight_next;
  logic                     r_mem_req;
  logic                     w_mem_req_next;
  logic                     w_grant;
  logic                     w_rsp;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_flush;
  logic                     w_bypass;
  logic                     w_inst_valid;
  logic [CNT_W-1:0]         w_count;
  logic [CNT_W-1:0]         w_count_next;
  logic [ADDR_W-1:0]        w_rsp_npc;
  logic [ADDR_W+INST_W-1:0] w_head;

  assign w_grant = r_mem_req && mem_gnt;

  // A response only counts against an outstanding request; INIT ignores leftovers
  assign w_rsp = mem_rvalid && (r_in_flight != CNT_ZERO) && (r_state != ST_INIT);

  // Requests are sequential and in order, so the oldest outstanding address is pc - in_flight
  assign w_rsp_npc = r_pc - ADDR_W'(r_in_flight) + ADDR_W'(1'b1);

`ifdef PREFETCH_BYPASS_EN
  assign w_bypass = (r_state == ST_FETCH) && w_rsp && (w_count == CNT_ZERO) && !target_en;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_inst_valid = (w_count != CNT_ZERO) || w_bypass;
  assign w_flush      = target_en;
  // Redirect wins over pop and push; a bypassed word consumed directly is never stored
  assign w_pop        = w_inst_valid && inst_ready && !target_en && !w_bypass;
  assign w_push       = (r_state == ST_FETCH) && w_rsp && !target_en && !(w_bypass && inst_ready);
  assign w_count_next = w_flush ? CNT_ZERO
                                : (w_count + CNT_W'(w_push) - CNT_W'(w_pop));

  fetch_fifo #(
    .WIDTH (ADDR_W + INST_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (w_flush),
    .i_push      (w_push),
    .i_push_data ({w_rsp_npc, from_mem_data}),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_count     (w_count)
  );

  assign mem_req     = r_mem_req;
  assign to_mem_addr = r_pc;
  assign inst_valid  = w_inst_valid;
  assign inst_if     = w_bypass ? from_mem_data : w_head[INST_W-1:0];
  assign npc_if      = w_bypass ? w_rsp_npc     : w_head[ADDR_W+INST_W-1:INST_W];

  // Next-state, next-pc, in-flight accounting and the registered request strobe
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_in_flight_next = r_in_flight + CNT_W'(w_grant) - CNT_W'(w_rsp);
    case (r_state)
      ST_INIT: begin
        w_state_next = ST_FETCH;
        if (target_en) begin
          w_pc_next = target;
        end else begin
          w_pc_next = r_pc;
        end
      end
      ST_FETCH: begin
        if (target_en) begin
          // A grant in this cycle is already counted in w_in_flight_next and will be drained
          w_pc_next = target;
          if (w_in_flight_next != CNT_ZERO) begin
            w_state_next = ST_DRAIN;
          end else begin
            w_state_next = ST_FETCH;
          end
        end else if (w_grant) begin
          w_pc_next = r_pc + ADDR_W'(1'b1);
        end else begin
          w_pc_next = r_pc;
        end
      end
      ST_DRAIN: begin
        if (target_en) begin
          w_pc_next = target;
        end else begin
          w_pc_next = r_pc;
        end
        if (w_in_flight_next == CNT_ZERO) begin
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_DRAIN;
        end
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
    w_mem_req_next = (w_state_next == ST_FETCH) &&
                     (({1'b0, w_count_next} + {1'b0, w_in_flight_next}) < DEPTH_W);
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_pc        <= RESET_PC;
      r_in_flight <= CNT_ZERO;
      r_mem_req   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_in_flight <= w_in_flight_next;
      r_mem_req   <= w_mem_req_next;
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_prefetch_queue
// Self-checking bench: a transaction-level memory plus a queue-based model of
// the prefetcher's outputs, compared on every cycle, and hand-computed
// literal expectations for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_prefetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [15:0] RST_PC = 16'h0010;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;

  logic        clk;
  logic        reset;
  logic [15:0] target;
  logic        target_en;
  logic        mem_req;
  logic        mem_gnt;
  logic [15:0] to_mem_addr;
  logic        mem_rvalid;
  logic [15:0] from_mem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_if;
  logic [15:0] npc_if;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model state
  int          m_phase;      // 0 init, 1 fetch, 2 drain
  logic [15:0] m_pc;
  logic [31:0] m_q[$];       // {npc, inst}
  int          m_out;
  mreq_t       mem_q[$];
  int          cyc;
  int          lat;
  logic [15:0] cur_addr;
  logic [31:0] rsp_word;
  logic        exp_mem_req;
  logic        exp_valid;
  logic        exp_byp;
  logic [15:0] exp_addr;
  logic [31:0] exp_word;
  bit          chk_en;
  logic [15:0] grant_log[$];
  logic [31:0] pop_log[$];

  prefetch_queue #(
    .ADDR_W   (16),
    .INST_W   (16),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .target        (target),
    .target_en     (target_en),
    .mem_req       (mem_req),
    .mem_gnt       (mem_gnt),
    .to_mem_addr   (to_mem_addr),
    .mem_rvalid    (mem_rvalid),
    .from_mem_data (from_mem_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_if       (inst_if),
    .npc_if        (npc_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] memdata(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] glog(input int i);
    if (i < grant_log.size()) return grant_log[i];
    else return 16'hxxxx;
  endfunction

  function automatic logic [31:0] plog(input int i);
    if (i < pop_log.size()) return pop_log[i];
    else return 32'hxxxx_xxxx;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Drive the memory response for this cycle and compute the expected outputs
  task automatic prep();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      mem_rvalid    = 1'b1;
      cur_addr      = mem_q[0].addr;
      from_mem_data = memdata(cur_addr);
    end else begin
      mem_rvalid    = 1'b0;
      cur_addr      = 16'h0000;
      from_mem_data = 16'h0000;
    end
    rsp_word    = {cur_addr + 16'h0001, memdata(cur_addr)};
    exp_mem_req = (m_phase == 1) && ((m_q.size() + m_out) < DEPTH);
    exp_addr    = m_pc;
    exp_byp     = 1'b0;
`ifdef PREFETCH_BYPASS_EN
    exp_byp = (m_phase == 1) && mem_rvalid && (m_out > 0) && (m_q.size() == 0) && !target_en;
`endif
    if (exp_byp) begin
      exp_valid = 1'b1;
      exp_word  = rsp_word;
    end else if (m_q.size() > 0) begin
      exp_valid = 1'b1;
      exp_word  = m_q[0];
    end else begin
      exp_valid = 1'b0;
      exp_word  = 32'h0;
    end
  endtask

  // Advance one clock and apply the behavioural rules to the model
  task automatic adv();
    logic g;
    logic pp;
    logic rv;
    int   out_new;
    @(posedge clk);
    g  = exp_mem_req && mem_gnt;
    pp = exp_valid && inst_ready;
    rv = mem_rvalid && (m_out > 0) && (m_phase != 0);
    if (reset) begin
      m_phase = 0;
      m_pc    = RST_PC;
      m_q.delete();
      m_out   = 0;
      mem_q.delete();
    end else begin
      if (g) mem_q.push_back('{addr: m_pc, due: cyc + lat});
      out_new = m_out + (g ? 1 : 0) - (rv ? 1 : 0);
      if (m_phase == 0) begin
        m_phase = 1;
        if (target_en) m_pc = target;
      end else if (target_en) begin
        m_q.delete();
        m_pc    = target;
        m_phase = (out_new > 0) ? 2 : 1;
      end else if (m_phase == 2) begin
        if (out_new == 0) m_phase = 1;
      end else begin
        if (g) m_pc = m_pc + 16'h0001;
        if (exp_byp) begin
          if (!inst_ready) m_q.push_back(rsp_word);
        end else begin
          if (pp) m_q.delete(0);
          if (rv) m_q.push_back(rsp_word);
        end
      end
      m_out = out_new;
      if (mem_rvalid) mem_q.delete(0);
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      prep();
      adv();
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", {31'b0, mem_req}, {31'b0, exp_mem_req});
      check("to_mem_addr", {16'h0, to_mem_addr}, {16'h0, exp_addr});
      check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        check("inst_if", {16'h0, inst_if}, {16'h0, exp_word[15:0]});
        check("npc_if", {16'h0, npc_if}, {16'h0, exp_word[31:16]});
      end
      if (mem_req && mem_gnt && !reset) grant_log.push_back(to_mem_addr);
      if (inst_valid && inst_ready && !target_en && !reset) pop_log.push_back({npc_if, inst_if});
    end
  end

  initial begin
    int base_g;
    int base_p;
    int drain_n;
    bit got;
    reset = 1'b1; target = 16'h0; target_en = 1'b0; mem_gnt = 1'b0; inst_ready = 1'b0;
    mem_rvalid = 1'b0; from_mem_data = 16'h0;
    lat = 1; cyc = 0; m_phase = 0; m_pc = RST_PC; m_out = 0; chk_en = 1'b0;
    run(3);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_addr", {16'h0, to_mem_addr}, 32'h0010);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", {16'h0, inst_if}, 32'h0);
    check("rst_npc", {16'h0, npc_if}, 32'h0);

    // sequential fetch from RESET_PC, 1-cycle latency, decode always ready
    mem_gnt = 1'b1; inst_ready = 1'b1;
    run(8);
    check("seq_addr0", {16'h0, glog(0)}, 32'h0010);
    check("seq_addr1", {16'h0, glog(1)}, 32'h0011);
    check("seq_addr2", {16'h0, glog(2)}, 32'h0012);
    check("seq_npc0", {16'h0, plog(0)[31:16]}, 32'h0011);
    check("seq_npc1", {16'h0, plog(1)[31:16]}, 32'h0012);
    check("seq_npc2", {16'h0, plog(2)[31:16]}, 32'h0013);
    check("seq_inst0", {16'h0, plog(0)[15:0]}, 32'h5A2C);

    // decode stalled: exactly DEPTH grants, then one grant per pop
    mem_gnt = 1'b0;
    run(4);
    inst_ready = 1'b0; mem_gnt = 1'b1;
    base_g = grant_log.size();
    run(10);
    check("stall_grants", grant_log.size() - base_g, 32'd4);
    check("stall_req_low", {31'b0, mem_req}, 32'd0);
    inst_ready = 1'b1;
    run(1);
    inst_ready = 1'b0;
    run(5);
    check("one_per_pop", grant_log.size() - base_g, 32'd5);

    // full queue streaming with simultaneous push and pop
    inst_ready = 1'b1;
    run(10);

    // redirect with two requests outstanding
    mem_gnt = 1'b0;
    run(5);
    lat = 3; mem_gnt = 1'b1;
    run(2);
    mem_gnt = 1'b0; target = 16'h0200; target_en = 1'b1;
    base_p = pop_log.size();
    run(1);
    target_en = 1'b0; mem_gnt = 1'b1;
    drain_n = 0;
    for (int i = 0; i < 20 && !mem_req; i++) begin
      run(1);
      drain_n++;
    end
    check("drain_cycles", drain_n, 32'd2);
    check("redir_addr", {16'h0, to_mem_addr}, 32'h0200);
    run(8);
    check("redir_npc", {16'h0, plog(base_p)[31:16]}, 32'h0201);
    check("redir_inst", {16'h0, plog(base_p)[15:0]}, 32'h583C);

    // address wrap from 0xFFFF
    mem_gnt = 1'b0;
    run(6);
    lat = 1; target = 16'hFFFF; target_en = 1'b1;
    run(1);
    target_en = 1'b0; mem_gnt = 1'b1;
    base_g = grant_log.size();
    base_p = pop_log.size();
    run(6);
    check("wrap_addr0", {16'h0, glog(base_g)}, 32'hFFFF);
    check("wrap_addr1", {16'h0, glog(base_g + 1)}, 32'h0000);
    check("wrap_npc0", {16'h0, plog(base_p)[31:16]}, 32'h0000);
    check("wrap_npc1", {16'h0, plog(base_p + 1)[31:16]}, 32'h0001);

    // reset in the middle of traffic
    inst_ready = 1'b0;
    run(3);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    check("midrst_req", {31'b0, mem_req}, 32'd0);
    check("midrst_valid", {31'b0, inst_valid}, 32'd0);
    check("midrst_addr", {16'h0, to_mem_addr}, 32'h0010);
    inst_ready = 1'b1;
    run(8);

    // single response into an empty queue (0xF1F1 ^ 0x5A3C = 0xABCD)
    mem_gnt = 1'b0;
    run(4);
    target = 16'hF1F1; target_en = 1'b1;
    run(1);
    target_en = 1'b0; mem_gnt = 1'b1;
    run(1);
    mem_gnt = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      prep();
      #1;
      if (mem_rvalid) begin
        got = 1'b1;
`ifdef PREFETCH_BYPASS_EN
        check("byp_valid", {31'b0, inst_valid}, 32'd1);
        check("byp_inst", {16'h0, inst_if}, 32'hABCD);
        check("byp_npc", {16'h0, npc_if}, 32'hF1F2);
        adv();
`else
        check("reg_valid_early", {31'b0, inst_valid}, 32'd0);
        adv();
        prep();
        #1;
        check("reg_valid", {31'b0, inst_valid}, 32'd1);
        check("reg_inst", {16'h0, inst_if}, 32'hABCD);
        check("reg_npc", {16'h0, npc_if}, 32'hF1F2);
        adv();
`endif
      end else begin
        adv();
      end
    end
    check("resp_seen", {31'b0, got}, 32'd1);
    run(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
